// File: rtl/axi_llc_flush_walker.sv
// Flush walker: sweeps every line of the selected ways through the tag-store port
// and forwards dirty-valid lines as eviction descriptors.
package axi_llc_pkg;
    typedef enum logic [1:0] {Bypass, Hit, Miss, Flush} llc_mode_e;
    typedef enum logic [1:0] {WalkIdle, WalkIssue, WalkDrain, WalkDone} walker_state_e;
endpackage

// Handshakes: a transfer happens on a rising clk edge where valid & ready are both high;
// a raised valid holds with stable payload until that edge.
module axi_llc_flush_walker
    import axi_llc_pkg::*;
#(
    parameter int unsigned NumWays        = 8,
    parameter int unsigned NumLines       = 256,
    parameter int unsigned TagLength      = 20,
    parameter int unsigned MaxOutstanding = 2,
    localparam int unsigned IdxW          = $clog2(NumLines)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_valid_i,
    output logic                 flush_ready_o,
    input  logic [NumWays-1:0]   flush_ways_i,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    output llc_mode_e            req_mode_o,
    output logic [IdxW-1:0]      req_index_o,
    output logic [NumWays-1:0]   req_indicator_o,
    input  logic                 res_valid_i,
    output logic                 res_ready_o,
    input  logic                 res_evict_i,
    input  logic [TagLength-1:0] res_evict_tag_i,
    output logic                 evict_valid_o,
    input  logic                 evict_ready_i,
    output logic [IdxW-1:0]      evict_index_o,
    output logic [NumWays-1:0]   evict_way_o,
    output logic [TagLength-1:0] evict_tag_o,
    output logic [NumWays-1:0]   flushed_o,
    output logic                 busy_o,
    output logic                 done_o,
    output walker_state_e        state_o
);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    walker_state_e       state_q, state_d;
    logic [NumWays-1:0]  mask_q, mask_d;
    logic [NumWays-1:0]  way_q, way_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [NumWays-1:0]  higher_ways, next_way;
    logic [CntW-1:0]     cnt_q;
    logic [PtrW-1:0]     wptr_q, rptr_q;
    logic [IdxW-1:0]     fifo_idx_q [MaxOutstanding];
    logic [NumWays-1:0]  fifo_way_q [MaxOutstanding];
    logic                accept, req_hs, res_hs, ev_hs;
    logic [NumWays-1:0]  flushed_clr, flushed_set;

    // Remaining selected ways strictly above the current one; its lowest bit is the next way.
    assign higher_ways = mask_q & ~(way_q | (way_q - 1'b1));
    assign next_way    = higher_ways & (~higher_ways + 1'b1);

    assign flush_ready_o   = (state_q == WalkIdle);
    assign busy_o          = (state_q != WalkIdle);
    assign done_o          = (state_q == WalkDone);
    assign state_o         = state_q;
    assign req_mode_o      = Flush;
    assign req_index_o     = idx_q;
    assign req_indicator_o = way_q;
    assign req_valid_o     = (state_q == WalkIssue) && (cnt_q < CntW'(MaxOutstanding));
    assign res_ready_o     = (cnt_q != '0) && (!evict_valid_o || evict_ready_i);
    assign accept          = flush_valid_i & flush_ready_o;
    assign req_hs          = req_valid_o & req_ready_i;
    assign res_hs          = res_valid_i & res_ready_o;
    assign ev_hs           = evict_valid_o & evict_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= WalkIdle;
            mask_q  <= '0;
            way_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            way_q   <= way_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        way_d   = way_q;
        idx_d   = idx_q;
        unique case (state_q)
            WalkIdle: begin
                if (accept) begin
                    if (flush_ways_i != '0) begin
                        state_d = WalkIssue;
                        mask_d  = flush_ways_i;
                        way_d   = flush_ways_i & (~flush_ways_i + 1'b1);
                        idx_d   = '0;
                    end else begin
                        state_d = WalkDone;
                    end
                end
            end
            WalkIssue: begin
                if (req_hs) begin
                    if (idx_q == IdxW'(NumLines - 1)) begin
                        idx_d = '0;
                        if (higher_ways == '0) begin
                            state_d = WalkDrain;
                        end else begin
                            way_d = next_way;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WalkDrain: begin
                if (cnt_q == '0 && !evict_valid_o) begin
                    state_d = WalkDone;
                end
            end
            WalkDone: state_d = WalkIdle;
            default:  state_d = WalkIdle;
        endcase
    end

    assign flushed_clr = (accept && flush_ways_i != '0) ? flush_ways_i : '0;
    assign flushed_set = (res_hs && fifo_idx_q[rptr_q] == IdxW'(NumLines - 1)) ?
                         fifo_way_q[rptr_q] : '0;

    // Pairing FIFO: responses arrive in issue order, so the head names the answered line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q         <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            evict_valid_o <= 1'b0;
            evict_index_o <= '0;
            evict_way_o   <= '0;
            evict_tag_o   <= '0;
            flushed_o     <= '0;
            for (int i = 0; i < int'(MaxOutstanding); i++) begin
                fifo_idx_q[i] <= '0;
                fifo_way_q[i] <= '0;
            end
        end else begin
            if (req_hs) begin
                fifo_idx_q[wptr_q] <= idx_q;
                fifo_way_q[wptr_q] <= way_q;
                wptr_q <= (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (res_hs) begin
                rptr_q <= (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + 1'b1;
            end
            if (req_hs && !res_hs) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!req_hs && res_hs) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (res_hs && res_evict_i) begin
                evict_valid_o <= 1'b1;
                evict_index_o <= fifo_idx_q[rptr_q];
                evict_way_o   <= fifo_way_q[rptr_q];
                evict_tag_o   <= res_evict_tag_i;
            end else if (ev_hs) begin
                evict_valid_o <= 1'b0;
            end
            flushed_o <= (flushed_o & ~flushed_clr) | flushed_set;
        end
    end
endmodule
